// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage states and constants.
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_000C;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/pc_next.sv
// pc_next: next-PC selection (aligned redirect, hold, +4) and misaligned-target flag.
module pc_next import fetch_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirectPc,
  input  logic             hold,
  output logic [WIDTH-1:0] nextPc,
  output logic             misalign
);
  assign nextPc = redirect ? {redirectPc[WIDTH-1:2], 2'b00} : hold ? pc : pc + WIDTH'(PC_INC);
  assign misalign = redirect & (|redirectPc[1:0]);
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, IF/ID pipeline register and BOOT/RUN/HALTED control.
module instruction_fetch import fetch_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] HALT_WORD = WIDTH'(DEF_HALT_WORD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] if_id_instr,
  output logic [WIDTH-1:0] if_id_pc_plus4,
  output logic             if_id_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [WIDTH-1:0] fetch_count
);
  fetch_state_t state, nextState;
  logic [WIDTH-1:0] pc, nextPc, pcPlus4;
  logic advance, isHalt, misalign, nextValid;
  assign imem_addr = pc;
  assign halted = state == HALTED;
  assign pcPlus4 = pc + WIDTH'(PC_INC);
  assign advance = state == RUN && !redirect && !stall;
  assign isHalt = advance && instr_in == HALT_WORD;
  // A stalled RUN keeps its current valid bit; every other non-advance cycle is a bubble.
  assign nextValid = advance || (state == RUN && stall && !redirect && if_id_valid);
  pc_next #(.WIDTH(WIDTH)) uPcNext (
    .pc(pc),
    .redirect(redirect),
    .redirectPc(redirect_pc),
    .hold(!advance || isHalt),
    .nextPc(nextPc),
    .misalign(misalign)
  );
  always_comb begin
    nextState = state;
    nextState = (state == BOOT || redirect) ? RUN : isHalt ? HALTED : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc_plus4 <= '0;
      if_id_valid <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= nextState;
      pc <= nextPc;
      if_id_valid <= nextValid;
      misalign_err <= misalign;
      if (advance) begin
        if_id_instr <= instr_in;
        if_id_pc_plus4 <= pcPlus4;
        fetch_count <= fetch_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch, stall, redirect, halt, wrap and reset.
module tb_instruction_fetch;
  logic clk = 1'b0, rst_n, stall, redirect, halted, misalign_err, if_id_valid;
  logic [31:0] redirect_pc, imem_addr, instr_in, if_id_instr, if_id_pc_plus4, fetch_count;
  logic [31:0] mem [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  always_comb instr_in = mem[imem_addr[9:2]];

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .instr_in(instr_in), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .halted(halted),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
    total++; if ({if_id_valid, halted, misalign_err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {if_id_valid, halted, misalign_err}); end
    total++; if (if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'h0) begin bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0/0/0", if_id_instr, if_id_pc_plus4, fetch_count); end
    rst_n = 1'b1;
    step();
    total++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL boot_cycle got valid=%b addr=%h exp valid=0 addr=0", if_id_valid, imem_addr); end
  endtask

  task automatic test_fetch();
    step();
    total++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0000 || if_id_pc_plus4 !== 32'h4) begin bad++; $display("FAIL fetch0 got v=%b i=%h p=%h exp v=1 i=a0000000 p=4", if_id_valid, if_id_instr, if_id_pc_plus4); end
    step();
    total++; if (if_id_instr !== 32'hA000_0001 || if_id_pc_plus4 !== 32'h8 || fetch_count !== 32'd2) begin bad++; $display("FAIL fetch1 got i=%h p=%h c=%0d exp i=a0000001 p=8 c=2", if_id_instr, if_id_pc_plus4, fetch_count); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (imem_addr !== 32'h8 || if_id_instr !== 32'hA000_0001 || fetch_count !== 32'd2 || if_id_valid !== 1'b1) begin bad++; $display("FAIL stall%0d got a=%h i=%h c=%0d v=%b exp a=8 i=a0000001 c=2 v=1", k, imem_addr, if_id_instr, fetch_count, if_id_valid); end
    end
    stall = 1'b0;
    step();
    total++; if (if_id_instr !== 32'hA000_0002 || if_id_pc_plus4 !== 32'hC || fetch_count !== 32'd3) begin bad++; $display("FAIL stall_resume got i=%h p=%h c=%0d exp i=a0000002 p=c c=3", if_id_instr, if_id_pc_plus4, fetch_count); end
  endtask

  task automatic test_redirect();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    total++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || misalign_err !== 1'b0 || fetch_count !== 32'd3) begin bad++; $display("FAIL redirect got a=%h v=%b m=%b c=%0d exp a=40 v=0 m=0 c=3", imem_addr, if_id_valid, misalign_err, fetch_count); end
    stall = 1'b0; redirect = 1'b0;
    step();
    total++; if (if_id_instr !== 32'hA000_0010 || if_id_pc_plus4 !== 32'h44 || fetch_count !== 32'd4 || if_id_valid !== 1'b1) begin bad++; $display("FAIL redirect_fetch got i=%h p=%h c=%0d v=%b exp i=a0000010 p=44 c=4 v=1", if_id_instr, if_id_pc_plus4, fetch_count, if_id_valid); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h42;
    step();
    total++; if (imem_addr !== 32'h40 || misalign_err !== 1'b1 || if_id_valid !== 1'b0) begin bad++; $display("FAIL misalign got a=%h m=%b v=%b exp a=40 m=1 v=0", imem_addr, misalign_err, if_id_valid); end
    redirect = 1'b0;
    step();
    total++; if (misalign_err !== 1'b0 || if_id_instr !== 32'hA000_0010 || fetch_count !== 32'd5) begin bad++; $display("FAIL misalign_clear got m=%b i=%h c=%0d exp m=0 i=a0000010 c=5", misalign_err, if_id_instr, fetch_count); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 32'h14;
    step();
    redirect = 1'b0;
    step();
    total++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0000_000C || if_id_pc_plus4 !== 32'h18 || fetch_count !== 32'd6) begin bad++; $display("FAIL halt_deliver got v=%b i=%h p=%h c=%0d exp v=1 i=c p=18 c=6", if_id_valid, if_id_instr, if_id_pc_plus4, fetch_count); end
    total++; if (halted !== 1'b1 || imem_addr !== 32'h14) begin bad++; $display("FAIL halt_state got h=%b a=%h exp h=1 a=14", halted, imem_addr); end
    stall = 1'b1;
    step();
    total++; if (if_id_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'h14 || fetch_count !== 32'd6) begin bad++; $display("FAIL halt_bubble got v=%b h=%b a=%h c=%0d exp v=0 h=1 a=14 c=6", if_id_valid, halted, imem_addr, fetch_count); end
    stall = 1'b0;
    step();
    total++; if (halted !== 1'b1 || imem_addr !== 32'h14 || if_id_valid !== 1'b0) begin bad++; $display("FAIL halt_hold got h=%b a=%h v=%b exp h=1 a=14 v=0", halted, imem_addr, if_id_valid); end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    total++; if (halted !== 1'b0 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin bad++; $display("FAIL halt_exit got h=%b a=%h v=%b exp h=0 a=0 v=0", halted, imem_addr, if_id_valid); end
    redirect = 1'b0;
    step();
    total++; if (if_id_instr !== 32'hA000_0000 || if_id_valid !== 1'b1 || fetch_count !== 32'd7) begin bad++; $display("FAIL halt_resume got i=%h v=%b c=%0d exp i=a0000000 v=1 c=7", if_id_instr, if_id_valid, fetch_count); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got a=%h exp a=fffffffc", imem_addr); end
    redirect = 1'b0;
    step();
    total++; if (imem_addr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_instr !== 32'hA000_00FF || fetch_count !== 32'd8) begin bad++; $display("FAIL wrap got a=%h p=%h i=%h c=%0d exp a=0 p=0 i=a00000ff c=8", imem_addr, if_id_pc_plus4, if_id_instr, fetch_count); end
  endtask

  task automatic test_async_reset();
    step();
    #3 rst_n = 1'b0;
    #1;
    total++; if (imem_addr !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || fetch_count !== 32'h0) begin bad++; $display("FAIL async_regs got a=%h i=%h p=%h c=%0d exp all 0", imem_addr, if_id_instr, if_id_pc_plus4, fetch_count); end
    total++; if ({if_id_valid, halted, misalign_err} !== 3'b000) begin bad++; $display("FAIL async_flags got %b exp 000", {if_id_valid, halted, misalign_err}); end
    step();
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h8;
    step();
    total++; if (imem_addr !== 32'h8 || if_id_valid !== 1'b0 || fetch_count !== 32'd0) begin bad++; $display("FAIL boot_redirect got a=%h v=%b c=%0d exp a=8 v=0 c=0", imem_addr, if_id_valid, fetch_count); end
    redirect = 1'b0;
    step();
    total++; if (if_id_instr !== 32'hA000_0002 || if_id_valid !== 1'b1 || fetch_count !== 32'd1) begin bad++; $display("FAIL boot_run got i=%h v=%b c=%0d exp i=a0000002 v=1 c=1", if_id_instr, if_id_valid, fetch_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[5] = 32'h0000_000C;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
